// File: rtl/dds_phase_gen_pkg.sv
// rtl/dds_phase_gen_pkg.sv - shared types and defaults for the DDS phase generator
// Contents: default widths, mode encodings, FSM state enum.
package dds_pkg;

  localparam int PHASE_W_DEF = 32;
  localparam int DIV_W_DEF   = 16;

  localparam logic [1:0] MODE_FIXED = 2'b00;
  localparam logic [1:0] MODE_ONCE  = 2'b01;
  localparam logic [1:0] MODE_LOOP  = 2'b10;
  localparam logic [1:0] MODE_TRI   = 2'b11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CONST      = 3'd1,
    SWEEP_UP   = 3'd2,
    SWEEP_DOWN = 3'd3,
    HOLD       = 3'd4
  } state_t;

endpackage

// File: rtl/dds_phase_gen_if.sv
// rtl/dds_phase_gen_if.sv - configuration/control/output bundle of the DDS phase generator
// Signals:
//   cfg_valid/cfg_ready        configuration handshake
//   ftw_start/ftw_stop/ftw_step tuning words for fixed or swept operation
//   step_div, mode             sweep step period minus one, operating mode
//   run, phase_sync            level enable, synchronous accumulator clear
//   DDS, wrap, sweep_done      phase word, carry pulse, sweep-end pulse
//   busy, cfg_err              not idle, latched config had start > stop in a sweep mode
// Modports: master drives configuration/control, slave is the phase generator.
interface dds_phase_gen_if #(
  parameter int PHASE_W = dds_pkg::PHASE_W_DEF,
  parameter int DIV_W   = dds_pkg::DIV_W_DEF
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [PHASE_W-1:0] ftw_start;
  logic [PHASE_W-1:0] ftw_stop;
  logic [PHASE_W-1:0] ftw_step;
  logic [DIV_W-1:0]   step_div;
  logic [1:0]         mode;
  logic               run;
  logic               phase_sync;
  logic [PHASE_W-1:0] DDS;
  logic               wrap;
  logic               sweep_done;
  logic               busy;
  logic               cfg_err;

  modport master (
    output cfg_valid, ftw_start, ftw_stop, ftw_step, step_div, mode, run, phase_sync,
    input  cfg_ready, DDS, wrap, sweep_done, busy, cfg_err
  );

  modport slave (
    input  cfg_valid, ftw_start, ftw_stop, ftw_step, step_div, mode, run, phase_sync,
    output cfg_ready, DDS, wrap, sweep_done, busy, cfg_err
  );
endinterface

// File: rtl/dds_phase_gen_sweep_step_timer.sv
// rtl/dds_phase_gen_sweep_step_timer.sv - sweep step divider
// Ports:
//   CLK, RESET   clock, asynchronous active-high reset
//   en           count this cycle (sweeping and running)
//   clr          restart the count at zero (sweep start)
//   div          step period minus one, in enabled cycles
//   tick         step strobe, high on the enabled cycle where the count equals div
module sweep_step_timer
  import dds_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  assign tick = en && (r_cnt == div);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/dds_phase_gen.sv
// rtl/dds_phase_gen.sv - phase accumulator with fixed or swept tuning word
// Ports:
//   CLK, RESET  clock, asynchronous active-high reset
//   bus         dds_phase_gen_if slave: config handshake, run/phase_sync
//               control, DDS phase word, wrap/sweep_done pulses, busy, cfg_err
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DIV_W   = DIV_W_DEF
) (
  input logic            CLK,
  input logic            RESET,
  dds_phase_gen_if.slave bus
);

  // latched configuration
  logic [PHASE_W-1:0] r_ftw_start;
  logic [PHASE_W-1:0] r_ftw_stop;
  logic [PHASE_W-1:0] r_ftw_step;
  logic [DIV_W-1:0]   r_step_div;
  logic [1:0]         r_mode;
  logic               r_cfg_loaded;
  logic               r_cfg_err;

  // datapath state
  state_t             r_state;
  state_t             w_state_next;
  logic [PHASE_W-1:0] r_ftw_cur;
  logic [PHASE_W-1:0] w_ftw_next;
  logic [PHASE_W-1:0] r_dds;
  logic               r_wrap;
  logic               r_sweep_done;
  logic               w_done_next;

  logic               w_idle;
  logic               w_start;
  logic               w_cfg_hs;
  logic               w_run_active;
  logic               w_sweeping;
  logic               w_tick;
  logic [PHASE_W:0]   w_up_sum;
  logic [PHASE_W:0]   w_dn_diff;
  logic [PHASE_W:0]   w_acc_sum;

  assign w_idle       = (r_state == IDLE);
  assign w_cfg_hs     = w_idle && bus.cfg_valid;
  assign w_start      = w_idle && bus.run && r_cfg_loaded;
  assign w_run_active = !w_idle && bus.run;
  assign w_sweeping   = bus.run && ((r_state == SWEEP_UP) || (r_state == SWEEP_DOWN));

  // One extra bit on each operation: carry for saturation/wrap, borrow for the floor.
  assign w_up_sum  = {1'b0, r_ftw_cur} + {1'b0, r_ftw_step};
  assign w_dn_diff = {1'b0, r_ftw_cur} - {1'b0, r_ftw_step};
  assign w_acc_sum = {1'b0, r_dds} + {1'b0, r_ftw_cur};

  sweep_step_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (w_sweeping),
    .clr   (w_start),
    .div   (r_step_div),
    .tick  (w_tick)
  );

  // Next state and tuning-word update.
  always_comb begin
    w_state_next = r_state;
    w_ftw_next   = r_ftw_cur;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_ftw_next = r_ftw_start;
          if ((r_mode == MODE_FIXED) || r_cfg_err) begin
            w_state_next = CONST;
          end else begin
            w_state_next = SWEEP_UP;
          end
        end
      end
      CONST, HOLD: begin
        if (!bus.run) begin
          w_state_next = IDLE;
        end
      end
      SWEEP_UP: begin
        if (!bus.run) begin
          w_state_next = IDLE;
        end else if (w_tick) begin
          // Loop mode sits at ftw_stop for one step period before restarting.
          if ((r_mode == MODE_LOOP) && (r_ftw_cur == r_ftw_stop)) begin
            w_ftw_next = r_ftw_start;
          end else if (w_up_sum >= {1'b0, r_ftw_stop}) begin
            w_ftw_next  = r_ftw_stop;
            w_done_next = 1'b1;
            case (r_mode)
              MODE_ONCE: w_state_next = HOLD;
              MODE_TRI:  w_state_next = SWEEP_DOWN;
              default:   w_state_next = SWEEP_UP;
            endcase
          end else begin
            w_ftw_next = w_up_sum[PHASE_W-1:0];
          end
        end
      end
      SWEEP_DOWN: begin
        if (!bus.run) begin
          w_state_next = IDLE;
        end else if (w_tick) begin
          if (w_dn_diff[PHASE_W] || (w_dn_diff[PHASE_W-1:0] <= r_ftw_start)) begin
            w_ftw_next   = r_ftw_start;
            w_state_next = SWEEP_UP;
          end else begin
            w_ftw_next = w_dn_diff[PHASE_W-1:0];
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ftw_start  <= '0;
      r_ftw_stop   <= '0;
      r_ftw_step   <= '0;
      r_step_div   <= '0;
      r_mode       <= MODE_FIXED;
      r_cfg_loaded <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else if (w_cfg_hs) begin
      r_ftw_start  <= bus.ftw_start;
      r_ftw_stop   <= bus.ftw_stop;
      r_ftw_step   <= bus.ftw_step;
      r_step_div   <= bus.step_div;
      r_mode       <= bus.mode;
      r_cfg_loaded <= 1'b1;
      r_cfg_err    <= (bus.mode != MODE_FIXED) && (bus.ftw_start > bus.ftw_stop);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ftw_cur    <= '0;
      r_sweep_done <= 1'b0;
    end else begin
      r_ftw_cur    <= w_ftw_next;
      r_sweep_done <= w_done_next;
    end
  end

  // Accumulator: phase_sync wins over the add in every state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_dds  <= '0;
      r_wrap <= 1'b0;
    end else if (bus.phase_sync) begin
      r_dds  <= '0;
      r_wrap <= 1'b0;
    end else if (w_run_active) begin
      r_dds  <= w_acc_sum[PHASE_W-1:0];
      r_wrap <= w_acc_sum[PHASE_W];
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign bus.cfg_ready  = w_idle;
  assign bus.busy       = !w_idle;
  assign bus.DDS        = r_dds;
  assign bus.wrap       = r_wrap;
  assign bus.sweep_done = r_sweep_done;
  assign bus.cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_dds_phase_gen.sv
// tb/tb_dds_phase_gen.sv - directed self-checking bench for dds_phase_gen
module tb_dds_phase_gen;
  import dds_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  dds_phase_gen_if #(.PHASE_W(32), .DIV_W(16)) bus ();

  dds_phase_gen #(.PHASE_W(32), .DIV_W(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] prev;
  logic [31:0] delta;
  logic [31:0] exp_d;

  task automatic step_clk();
    @(posedge CLK);
    #1;
  endtask

  task automatic track();
    delta = bus.DDS - prev;
    prev  = bus.DDS;
  endtask

  task automatic do_cfg(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                        input logic [15:0] d, input logic [1:0] m);
    bus.ftw_start = s;
    bus.ftw_stop  = p;
    bus.ftw_step  = st;
    bus.step_div  = d;
    bus.mode      = m;
    bus.cfg_valid = 1'b1;
    step_clk();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic stop_run();
    bus.run = 1'b0;
    step_clk();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.cfg_valid = 1'b0; bus.ftw_start = '0; bus.ftw_stop = '0; bus.ftw_step = '0;
    bus.step_div = '0; bus.mode = MODE_FIXED; bus.run = 1'b0; bus.phase_sync = 1'b0;
    repeat (3) step_clk();
    checks++; if (bus.DDS !== 32'h0) begin failures++; $display("FAIL reset_dds got=%h exp=0", bus.DDS); end
    checks++; if (bus.wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap); end
    checks++; if (bus.sweep_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.sweep_done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", bus.cfg_err); end
    checks++; if (bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%b exp=1", bus.cfg_ready); end
    RESET = 1'b0;
    step_clk();
  endtask

  task automatic test_fixed();
    do_cfg(32'h4000_0000, 32'h0, 32'h0, 16'd0, MODE_FIXED);
    bus.run = 1'b1;
    step_clk();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL fixed_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL fixed_cfg_ready got=%b exp=0", bus.cfg_ready); end
    checks++; if (bus.DDS !== 32'h0) begin failures++; $display("FAIL fixed_first_edge got=%h exp=0", bus.DDS); end
    for (int i = 1; i <= 7; i++) begin
      step_clk();
      exp_d = 32'h4000_0000 * i;
      checks++; if (bus.DDS !== exp_d) begin failures++; $display("FAIL fixed_dds[%0d] got=%h exp=%h", i, bus.DDS, exp_d); end
      checks++; if (bus.wrap !== (i % 4 == 0)) begin failures++; $display("FAIL fixed_wrap[%0d] got=%b exp=%b", i, bus.wrap, (i % 4 == 0)); end
    end
    stop_run();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL fixed_stop_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.DDS !== 32'hC000_0000) begin failures++; $display("FAIL fixed_hold got=%h exp=c0000000", bus.DDS); end
    checks++; if (bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL fixed_stop_ready got=%b exp=1", bus.cfg_ready); end
  endtask

  task automatic test_sweep_once();
    do_cfg(32'h100, 32'h400, 32'h100, 16'd3, MODE_ONCE);
    bus.run = 1'b1;
    step_clk();
    prev = bus.DDS;
    for (int k = 1; k <= 16; k++) begin
      step_clk();
      track();
      exp_d = (k <= 4) ? 32'h100 : (k <= 8) ? 32'h200 : (k <= 12) ? 32'h300 : 32'h400;
      checks++; if (delta !== exp_d) begin failures++; $display("FAIL once_ftw[%0d] got=%h exp=%h", k, delta, exp_d); end
      checks++; if (bus.sweep_done !== (k == 12)) begin failures++; $display("FAIL once_done[%0d] got=%b exp=%b", k, bus.sweep_done, (k == 12)); end
    end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL once_hold_busy got=%b exp=1", bus.busy); end
    stop_run();
  endtask

  task automatic test_triangle();
    logic [31:0] tv [10];
    tv = '{32'h10, 32'h20, 32'h30, 32'h35, 32'h25, 32'h15, 32'h10, 32'h20, 32'h30, 32'h35};
    do_cfg(32'h10, 32'h35, 32'h10, 16'd0, MODE_TRI);
    bus.run = 1'b1;
    step_clk();
    prev = bus.DDS;
    for (int k = 1; k <= 10; k++) begin
      step_clk();
      track();
      checks++; if (delta !== tv[k-1]) begin failures++; $display("FAIL tri_ftw[%0d] got=%h exp=%h", k, delta, tv[k-1]); end
      checks++; if (bus.sweep_done !== (k == 3 || k == 9)) begin failures++; $display("FAIL tri_done[%0d] got=%b exp=%b", k, bus.sweep_done, (k == 3 || k == 9)); end
    end
    stop_run();
  endtask

  task automatic test_phase_sync();
    do_cfg(32'h10, 32'h0, 32'h0, 16'd0, MODE_FIXED);
    bus.run = 1'b1;
    repeat (3) step_clk();
    bus.phase_sync = 1'b1;
    step_clk();
    bus.phase_sync = 1'b0;
    checks++; if (bus.DDS !== 32'h0) begin failures++; $display("FAIL sync_clear got=%h exp=0", bus.DDS); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL sync_busy got=%b exp=1", bus.busy); end
    step_clk();
    checks++; if (bus.DDS !== 32'h10) begin failures++; $display("FAIL sync_after1 got=%h exp=10", bus.DDS); end
    step_clk();
    checks++; if (bus.DDS !== 32'h20) begin failures++; $display("FAIL sync_after2 got=%h exp=20", bus.DDS); end
    bus.run = 1'b0;
    bus.phase_sync = 1'b1;
    step_clk();
    bus.phase_sync = 1'b0;
    checks++; if (bus.DDS !== 32'h0) begin failures++; $display("FAIL sync_stop_dds got=%h exp=0", bus.DDS); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL sync_stop_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_busy_cfg();
    bus.run = 1'b1;
    step_clk();
    prev = bus.DDS;
    bus.ftw_start = 32'h999;
    bus.mode = MODE_TRI;
    bus.cfg_valid = 1'b1;
    #1;
    checks++; if (bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL busy_cfg_ready got=%b exp=0", bus.cfg_ready); end
    step_clk();
    bus.cfg_valid = 1'b0;
    track();
    checks++; if (delta !== 32'h10) begin failures++; $display("FAIL busy_cfg_ftw got=%h exp=10", delta); end
    stop_run();
    bus.run = 1'b1;
    step_clk();
    prev = bus.DDS;
    step_clk();
    track();
    checks++; if (delta !== 32'h10) begin failures++; $display("FAIL busy_cfg_restart got=%h exp=10", delta); end
    stop_run();
  endtask

  task automatic test_cfg_err();
    do_cfg(32'h500, 32'h100, 32'h10, 16'd0, MODE_ONCE);
    checks++; if (bus.cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_flag got=%b exp=1", bus.cfg_err); end
    bus.run = 1'b1;
    step_clk();
    prev = bus.DDS;
    for (int k = 1; k <= 4; k++) begin
      step_clk();
      track();
      checks++; if (delta !== 32'h500) begin failures++; $display("FAIL cfg_err_ftw[%0d] got=%h exp=500", k, delta); end
      checks++; if (bus.sweep_done !== 1'b0) begin failures++; $display("FAIL cfg_err_done[%0d] got=%b exp=0", k, bus.sweep_done); end
    end
    stop_run();
  endtask

  task automatic test_loop_reset();
    logic [31:0] lv [4];
    lv = '{32'h100, 32'h200, 32'h300, 32'h100};
    do_cfg(32'h100, 32'h300, 32'h100, 16'd0, MODE_LOOP);
    checks++; if (bus.cfg_err !== 1'b0) begin failures++; $display("FAIL loop_cfg_err got=%b exp=0", bus.cfg_err); end
    bus.run = 1'b1;
    step_clk();
    prev = bus.DDS;
    for (int k = 1; k <= 4; k++) begin
      step_clk();
      track();
      checks++; if (delta !== lv[k-1]) begin failures++; $display("FAIL loop_ftw[%0d] got=%h exp=%h", k, delta, lv[k-1]); end
      checks++; if (bus.sweep_done !== (k == 2)) begin failures++; $display("FAIL loop_done[%0d] got=%b exp=%b", k, bus.sweep_done, (k == 2)); end
    end
    #1;
    RESET = 1'b1;
    #1;
    checks++; if (bus.DDS !== 32'h0) begin failures++; $display("FAIL rst_mid_dds got=%h exp=0", bus.DDS); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", bus.cfg_ready); end
    checks++; if (bus.wrap !== 1'b0 || bus.sweep_done !== 1'b0 || bus.cfg_err !== 1'b0) begin
      failures++; $display("FAIL rst_mid_flags got=%b%b%b exp=000", bus.wrap, bus.sweep_done, bus.cfg_err);
    end
    step_clk();
    RESET = 1'b0;
    repeat (3) step_clk();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_norun_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.DDS !== 32'h0) begin failures++; $display("FAIL rst_norun_dds got=%h exp=0", bus.DDS); end
    bus.run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_sweep_once();
    test_triangle();
    test_phase_sync();
    test_busy_cfg();
    test_cfg_err();
    test_loop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_phase_gen.md
# dds_phase_gen

Phase-accumulator core that produces the 32-bit `DDS` phase word consumed by the waveform-shaping stage. It sits upstream of the form/wave selector and owns frequency control. It supports a fixed tuning word or a linear frequency sweep (once, looped, triangle), driven by a latched configuration. It also provides a phase-sync clear and a wrap pulse, so downstream logic can align to the waveform period.

## Interface
- `PHASE_W`, 32, accumulator and tuning-word width
- `DIV_W`, 16, sweep step-divider width
- `CLK`  in  1  clock
- `RESET`  in  1  reset, asynchronous, active-high
- `cfg_valid`  in  1  configuration offered
- `cfg_ready`  out  1  configuration accepted this cycle if `cfg_valid`
- `ftw_start`  in  PHASE_W  start (or fixed) tuning word
- `ftw_stop`  in  PHASE_W  sweep end tuning word
- `ftw_step`  in  PHASE_W  tuning-word increment per sweep step
- `step_div`  in  DIV_W  sweep step period minus one, in clocks
- `mode`  in  2  00 fixed, 01 sweep-once, 10 sweep-loop, 11 sweep-triangle
- `run`  in  1  level enable
- `phase_sync`  in  1  synchronous accumulator clear
- `DDS`  out  PHASE_W  phase word
- `wrap`  out  1  one-cycle pulse on accumulator carry-out
- `sweep_done`  out  1  one-cycle pulse when `ftw_cur` reaches `ftw_stop`
- `busy`  out  1  state ≠ IDLE
- `cfg_err`  out  1  latched config had `ftw_start > ftw_stop` in a sweep mode

## Operation
- States: IDLE, CONST, SWEEP_UP, SWEEP_DOWN, HOLD.
- `cfg_ready` = (state == IDLE). A handshake latches all cfg inputs and sets `cfg_loaded`. `cfg_valid` outside IDLE is ignored.
- IDLE → (`run` && `cfg_loaded`):
  - Go to CONST for mode 00 or `cfg_err`; otherwise go to SWEEP_UP.
  - `ftw_cur <= ftw_start`; divider count `<= 0`.
- Any active state with `run == 0` → IDLE next edge. `DDS` holds its last value; `ftw_cur` is retained but reloaded on the next start.
- Active states: `DDS <= DDS + ftw_cur` every edge, modulo 2^PHASE_W.
- `wrap` is registered with `DDS`: high when the 33-bit sum carries.
- `phase_sync`, in any state, forces `DDS <= 0` and `wrap <= 0` for that edge. It overrides the add. `ftw_cur` and the state are unaffected.
- Sweep divider:
  - Counts active cycles in SWEEP_UP/SWEEP_DOWN.
  - At `cnt == step_div` it issues a step tick and sets `cnt <= 0`.
- SWEEP_UP step: 33-bit `ftw_cur + ftw_step`; if the sum ≥ `ftw_stop`, set `ftw_cur <= ftw_stop` and pulse `sweep_done`. Then, by mode:
  - 01: go to HOLD (constant accumulation at `ftw_stop`).
  - 10: stay in SWEEP_UP; the next tick sets `ftw_cur <= ftw_start`.
  - 11: go to SWEEP_DOWN.
- SWEEP_DOWN step: `ftw_cur - ftw_step`, floored at `ftw_start` (no underflow). On reaching `ftw_start`, go to SWEEP_UP.
- `ftw_step == 0`: the sweep never advances, which is legal. `step_div == 0`: a step tick every cycle.
- All arithmetic is unsigned.

## Timing
- Reset values:
  - `DDS` = 0, `ftw_cur` = 0, `cnt` = 0
  - `wrap` = 0, `sweep_done` = 0, `busy` = 0, `cfg_err` = 0
  - `cfg_loaded` = 0, state IDLE
  - `cfg_ready` = 1
- Config handshake at edge N → latched values are usable at edge N+1.
- `run` sampled high at edge S (IDLE) → active at S. The first `DDS` increment is at S+1, using `ftw_start`.
- Step tick on the edge where `cnt == step_div`. That edge's add uses the old `ftw_cur`, and the new value applies from the next edge. The first change comes `step_div+1` active edges after the sweep starts.
- `sweep_done` and `wrap` are high exactly one cycle.
- `run` low together with `phase_sync`: both take effect, giving `DDS` = 0 and IDLE.
- `RESET` mid-sweep: immediate return to reset values. A new config handshake is required before running again.

## Structure
- Package `dds_pkg`:
  - mode encodings (`MODE_FIXED`, `MODE_ONCE`, `MODE_LOOP`, `MODE_TRI`)
  - state enum
  - default `PHASE_W`/`DIV_W`
- Sub-module `sweep_step_timer`: the DIV_W divider, with inputs `en`, `clr`, `div` and output `tick`.
- Top level: config registers, FSM, tuning-word update, accumulator, wrap/done pulses.

## Test plan
- Fixed mode, `ftw_start` = 0x4000_0000, `run` = 1: `DDS` steps 0x4000_0000, 0x8000_0000, 0xC000_0000, 0x0000_0000. `wrap` is high only on the edge that produces 0x0000_0000, then repeats every 4 cycles.
- Sweep-once, start 0x100, stop 0x400, step 0x100, `step_div` 3:
  - `ftw_cur` changes every 4 cycles: 0x200, 0x300, 0x400.
  - `sweep_done` is a single pulse at 0x400, then HOLD.
  - `DDS` keeps advancing by 0x400 per cycle.
- Triangle, start 0x10, stop 0x35, step 0x10, `step_div` 0: `ftw_cur` sequence is 0x20, 0x30, 0x35 (saturated, `sweep_done`), 0x25, 0x15, 0x10 (floored), 0x20, …
- `phase_sync` pulse mid-run with fixed `ftw` 0x10: `DDS` = 0 the next cycle, then 0x10, 0x20.
- `cfg_valid` while busy: no latch, `cfg_ready` = 0. Start 0x500 > stop 0x100 in sweep mode: `cfg_err` = 1 and constant accumulation at 0x500.
- `RESET` asserted mid-sweep: all outputs at reset values on that edge. `run` = 1 without a new config keeps the block in IDLE.
